// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-serial RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int BLOCK_WIDTH = 4;
  localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
  localparam int LINE_BITS   = BLOCK_SIZE * 8;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} arbState_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_IC, REQ_DC, REQ_IO} reqId_t;

  typedef logic [BLOCK_WIDTH:0] cnt_t;

  function automatic logic isIoRegion(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

  function automatic cnt_t ioBurstLen(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return cnt_t'(1);
      SIZE_HALF: return cnt_t'(2);
      default:   return cnt_t'(4);
    endcase
  endfunction

  function automatic logic [7:0] selByte(input logic [LINE_BITS-1:0] line,
                                         input logic [BLOCK_WIDTH-1:0] idx);
    return line[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Byte counter, RAM address generation, read capture and write-byte selection
// for one burst of len bytes starting at base.
module mem_byte_sequencer
  import mem_port_arbiter_pkg::*;
(
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] loadData,
  input  logic                 readEn,
  input  logic                 writeEn,
  input  logic                 stall,
  input  logic [31:0]          base,
  input  cnt_t                 len,
  input  logic [7:0]           memIn,
  output logic [31:0]          memAddrOut,
  output logic [7:0]           memOut,
  output logic                 memWriteOut,
  output logic                 last,
  output logic [LINE_BITS-1:0] lineNext
);

  cnt_t                   cnt;
  logic [LINE_BITS-1:0]   lineBuf;
  logic [BLOCK_WIDTH-1:0] wrIdx;
  logic [BLOCK_WIDTH-1:0] capIdx;
  logic                   advance;

  assign wrIdx  = cnt[BLOCK_WIDTH-1:0];
  assign capIdx = wrIdx - BLOCK_WIDTH'(1);

  // Read data lags the address by one cycle, so byte cnt-1 arrives while cnt is driven.
  always_comb begin
    memAddrOut  = '0;
    memOut      = '0;
    memWriteOut = 1'b0;
    advance     = 1'b0;
    last        = 1'b0;
    lineNext    = lineBuf;
    if (readEn) begin
      advance = 1'b1;
      if (cnt < len) memAddrOut = base + 32'(cnt);
      if (cnt != '0) lineNext[{capIdx, 3'b000} +: 8] = memIn;
      last = (cnt == len);
    end else if (writeEn) begin
      memAddrOut  = base + 32'(cnt);
      memOut      = selByte(lineBuf, wrIdx);
      memWriteOut = !stall;
      advance     = !stall;
      last        = !stall && (cnt == len - cnt_t'(1));
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt     <= '0;
      lineBuf <= '0;
    end else if (load) begin
      cnt     <= '0;
      lineBuf <= loadData;
    end else begin
      if (advance) cnt <= cnt + cnt_t'(1);
      lineBuf <= lineNext;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide RAM port between ICache, DCache and uncached IO,
// turning each grant into a byte-serial burst with a one-cycle done pulse.
//
// state    | meaning
// ST_IDLE  | no burst; fixed-priority grant IO > DC > IC
// ST_READ  | read burst in progress (ICache read abortable by clearIn)
// ST_WRITE | write burst in progress, may stall on full IO buffer
// ST_DONE  | done pulse to the granted requester, then back to idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    clearIn,
  input  logic                    icReqIn,
  input  logic [31:BLOCK_WIDTH]   icAddrIn,
  output logic                    icDoneOut,
  output logic [LINE_BITS-1:0]    icLineOut,
  input  logic                    dcReqIn,
  input  logic                    dcWriteIn,
  input  logic [31:BLOCK_WIDTH]   dcAddrIn,
  input  logic [LINE_BITS-1:0]    dcLineIn,
  output logic                    dcDoneOut,
  output logic [LINE_BITS-1:0]    dcLineOut,
  input  logic                    ioReqIn,
  input  logic                    ioWriteIn,
  input  logic [1:0]              ioSizeIn,
  input  logic [31:0]             ioAddrIn,
  input  logic [31:0]             ioDataIn,
  output logic                    ioDoneOut,
  output logic [31:0]             ioDataOut,
  input  logic                    ioBufferFullIn,
  input  logic [7:0]              memIn,
  output logic [31:0]             memAddrOut,
  output logic [7:0]              memOut,
  output logic                    memWriteOut
);

  arbState_t            state, stateNext;
  reqId_t               grantId, grantIdNext;
  logic [31:0]          baseReg, baseNext;
  cnt_t                 lenReg, lenNext;
  logic                 writeNext;
  logic                 load;
  logic                 abort;
  logic                 last;
  logic                 stall;
  logic [LINE_BITS-1:0] loadData;
  logic [LINE_BITS-1:0] lineNext;

  always_comb begin
    stateNext   = state;
    grantIdNext = REQ_NONE;
    baseNext    = '0;
    lenNext     = '0;
    writeNext   = 1'b0;
    loadData    = '0;
    load        = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ioReqIn && ioSizeIn != SIZE_NONE) begin
          load        = 1'b1;
          grantIdNext = REQ_IO;
          baseNext    = ioAddrIn;
          lenNext     = ioBurstLen(ioSizeIn);
          writeNext   = ioWriteIn;
          if (ioWriteIn) loadData = LINE_BITS'(ioDataIn);
        end else if (dcReqIn) begin
          load        = 1'b1;
          grantIdNext = REQ_DC;
          baseNext    = {dcAddrIn, {BLOCK_WIDTH{1'b0}}};
          lenNext     = cnt_t'(BLOCK_SIZE);
          writeNext   = dcWriteIn;
          if (dcWriteIn) loadData = dcLineIn;
        end else if (icReqIn && !clearIn) begin
          load        = 1'b1;
          grantIdNext = REQ_IC;
          baseNext    = {icAddrIn, {BLOCK_WIDTH{1'b0}}};
          lenNext     = cnt_t'(BLOCK_SIZE);
        end
        if (load) stateNext = writeNext ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (grantId == REQ_IC && clearIn) begin
          abort     = 1'b1;
          stateNext = ST_IDLE;
        end else if (last) begin
          stateNext = ST_DONE;
        end
      end
      ST_WRITE: if (last) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  assign stall = (state == ST_WRITE) && (grantId == REQ_IO) &&
                 isIoRegion(baseReg) && ioBufferFullIn;

  mem_byte_sequencer uSeq (
    .clkIn       (clkIn),
    .resetIn     (resetIn),
    .load        (load),
    .loadData    (loadData),
    .readEn      (state == ST_READ),
    .writeEn     (state == ST_WRITE),
    .stall       (stall),
    .base        (baseReg),
    .len         (lenReg),
    .memIn       (memIn),
    .memAddrOut  (memAddrOut),
    .memOut      (memOut),
    .memWriteOut (memWriteOut),
    .last        (last),
    .lineNext    (lineNext)
  );

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state     <= ST_IDLE;
      grantId   <= REQ_NONE;
      baseReg   <= '0;
      lenReg    <= '0;
      icLineOut <= '0;
      dcLineOut <= '0;
      ioDataOut <= '0;
    end else begin
      state <= stateNext;
      if (load) begin
        grantId <= grantIdNext;
        baseReg <= baseNext;
        lenReg  <= lenNext;
      end
      // Result registers update only on a completed read, so an abort leaves them intact.
      if (state == ST_READ && last && !abort) begin
        case (grantId)
          REQ_IC:  icLineOut <= lineNext;
          REQ_DC:  dcLineOut <= lineNext;
          REQ_IO:  ioDataOut <= lineNext[31:0];
          default: ;
        endcase
      end
    end
  end

  assign icDoneOut = (state == ST_DONE) && (grantId == REQ_IC);
  assign dcDoneOut = (state == ST_DONE) && (grantId == REQ_DC);
  assign ioDoneOut = (state == ST_DONE) && (grantId == REQ_IO);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of IO transfers plus hand-written
// cache refill/write-back, stall, priority, abort and reset sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic                  clkIn = 1'b0;
  logic                  resetIn = 1'b0;
  logic                  clearIn = 1'b0;
  logic                  icReqIn = 1'b0;
  logic [31:BLOCK_WIDTH] icAddrIn = '0;
  logic                  icDoneOut;
  logic [LINE_BITS-1:0]  icLineOut;
  logic                  dcReqIn = 1'b0;
  logic                  dcWriteIn = 1'b0;
  logic [31:BLOCK_WIDTH] dcAddrIn = '0;
  logic [LINE_BITS-1:0]  dcLineIn = '0;
  logic                  dcDoneOut;
  logic [LINE_BITS-1:0]  dcLineOut;
  logic                  ioReqIn = 1'b0;
  logic                  ioWriteIn = 1'b0;
  logic [1:0]            ioSizeIn = 2'b00;
  logic [31:0]           ioAddrIn = '0;
  logic [31:0]           ioDataIn = '0;
  logic                  ioDoneOut;
  logic [31:0]           ioDataOut;
  logic                  ioBufferFullIn = 1'b0;
  logic [7:0]            memIn = '0;
  logic [31:0]           memAddrOut;
  logic [7:0]            memOut;
  logic                  memWriteOut;

  mem_port_arbiter dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .icReqIn(icReqIn), .icAddrIn(icAddrIn), .icDoneOut(icDoneOut), .icLineOut(icLineOut),
    .dcReqIn(dcReqIn), .dcWriteIn(dcWriteIn), .dcAddrIn(dcAddrIn), .dcLineIn(dcLineIn),
    .dcDoneOut(dcDoneOut), .dcLineOut(dcLineOut),
    .ioReqIn(ioReqIn), .ioWriteIn(ioWriteIn), .ioSizeIn(ioSizeIn), .ioAddrIn(ioAddrIn),
    .ioDataIn(ioDataIn), .ioDoneOut(ioDoneOut), .ioDataOut(ioDataOut),
    .ioBufferFullIn(ioBufferFullIn), .memIn(memIn), .memAddrOut(memAddrOut),
    .memOut(memOut), .memWriteOut(memWriteOut)
  );

  always #5 clkIn = ~clkIn;

  // RAM model: one-cycle read latency, content = address low byte XOR memXor
  logic [7:0] memXor = '0;
  always @(posedge clkIn) memIn <= memAddrOut[7:0] ^ memXor;

  int passCnt = 0;
  int totalCnt = 0;
  logic [31:0]  rdQ[$];
  logic [39:0]  wrQ[$];
  logic [2:0]   doneMask;
  int           lat;
  int           icDones, dcLat, act;
  logic [127:0] expIcLine;
  logic [31:0]  wdat;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  xorKey;
    logic        bufFull;
    int          expLat;
    logic [31:0] expData;
  } ioVec_t;
  ioVec_t vecs[10];

  task automatic chk(input string name, input logic [127:0] actual, input logic [127:0] required);
    totalCnt++;
    if (actual === required) passCnt++;
    else $display("FAIL %s: got %0h required %0h", name, actual, required);
  endtask

  task automatic chkInt(input string name, input int actual, input int required);
    totalCnt++;
    if (actual == required) passCnt++;
    else $display("FAIL %s: got %0d required %0d", name, actual, required);
  endtask

  function automatic logic [127:0] lineOf(input logic [31:0] base, input logic [7:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(base[7:0] + 8'(k)) ^ x;
    return r;
  endfunction

  function automatic int ioLen(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  // Waits up to maxK negedges for any done; logs RAM activity; lat=0 on timeout.
  task automatic runBurst(input int maxK, input int stallFrom, input int stallLen);
    lat = 0;
    doneMask = '0;
    rdQ.delete();
    wrQ.delete();
    for (int k = 1; k <= maxK; k++) begin
      @(negedge clkIn);
      ioBufferFullIn = (k >= stallFrom) && (k < stallFrom + stallLen);
      #1;
      if (memWriteOut) wrQ.push_back({memAddrOut, memOut});
      else if (memAddrOut != 0) rdQ.push_back(memAddrOut);
      doneMask = {ioDoneOut, dcDoneOut, icDoneOut};
      if (doneMask != 3'b000) begin
        lat = k;
        break;
      end
    end
    ioBufferFullIn = 1'b0;
  endtask

  task automatic checkGap(input string name);
    @(negedge clkIn);
    #1;
    chk(name, 128'({memWriteOut, memAddrOut, ioDoneOut, dcDoneOut, icDoneOut}), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 2'b01, 32'h0003_0004, 32'h0,         8'h45, 1'b0, 3, 32'h0000_0041};
    vecs[1] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,         8'hA0, 1'b0, 4, 32'h0000_A1A0};
    vecs[2] = '{1'b0, 2'b11, 32'h0000_0240, 32'h0,         8'h00, 1'b0, 6, 32'h4342_4140};
    vecs[3] = '{1'b0, 2'b01, 32'h0000_0007, 32'h0,         8'h80, 1'b0, 3, 32'h0000_0087};
    vecs[4] = '{1'b1, 2'b01, 32'h0000_0050, 32'h1234_56AB, 8'h00, 1'b0, 2, 32'h0000_0087};
    vecs[5] = '{1'b1, 2'b10, 32'h0000_0060, 32'hFFFF_1234, 8'h00, 1'b0, 3, 32'h0000_0087};
    vecs[6] = '{1'b1, 2'b11, 32'h0003_0010, 32'hCAFE_F00D, 8'h00, 1'b0, 5, 32'h0000_0087};
    vecs[7] = '{1'b1, 2'b01, 32'h0002_0070, 32'h0000_005A, 8'h00, 1'b1, 2, 32'h0000_0087};
    vecs[8] = '{1'b0, 2'b00, 32'h0000_0080, 32'h0,         8'h00, 1'b0, 0, 32'h0000_0087};
    vecs[9] = '{1'b0, 2'b10, 32'h0003_000E, 32'h0,         8'h00, 1'b1, 4, 32'h0000_0F0E};

    // reset state
    repeat (3) @(negedge clkIn);
    #1;
    chk("reset mem port", 128'({memAddrOut, memOut, memWriteOut}), 128'(0));
    chk("reset dones", 128'({icDoneOut, dcDoneOut, ioDoneOut}), 128'(0));
    chk("reset icLine", icLineOut, 128'(0));
    chk("reset dcLine", dcLineOut, 128'(0));
    chk("reset ioData", 128'(ioDataOut), 128'(0));
    resetIn = 1'b1;

    // ICache refill of line 0x00001
    memXor = 8'h00; icAddrIn = 28'h1; icReqIn = 1'b1;
    runBurst(30, 0, 0);
    icReqIn = 1'b0;
    chkInt("ic latency", lat, 18);
    chk("ic done", 128'(doneMask), 128'(3'b001));
    expIcLine = lineOf(32'h10, 8'h00);
    chk("ic line", icLineOut, expIcLine);
    chkInt("ic addr count", rdQ.size(), 16);
    for (int j = 0; j < rdQ.size(); j++)
      chk($sformatf("ic addr %0d", j), 128'(rdQ[j]), 128'(32'h10 + 32'(j)));
    checkGap("ic gap");

    // DCache write-back of line 0x00002
    for (int k = 0; k < 16; k++) dcLineIn[k*8 +: 8] = 8'(k);
    dcAddrIn = 28'h2; dcWriteIn = 1'b1; dcReqIn = 1'b1;
    runBurst(30, 0, 0);
    dcReqIn = 1'b0; dcWriteIn = 1'b0;
    chkInt("dc wb latency", lat, 17);
    chk("dc wb done", 128'(doneMask), 128'(3'b010));
    chkInt("dc wb write count", wrQ.size(), 16);
    for (int j = 0; j < wrQ.size(); j++)
      chk($sformatf("dc wb byte %0d", j), 128'(wrQ[j]), 128'({32'h20 + 32'(j), 8'(j)}));
    checkGap("dc wb gap");

    // IO word write into the buffered region with a 3-cycle full stall
    wdat = 32'hDEAD_BEEF;
    ioAddrIn = 32'h0003_0000; ioDataIn = wdat; ioWriteIn = 1'b1; ioSizeIn = SIZE_WORD; ioReqIn = 1'b1;
    runBurst(20, 3, 3);
    ioReqIn = 1'b0;
    chkInt("io stall latency", lat, 8);
    chk("io stall done", 128'(doneMask), 128'(3'b100));
    chkInt("io stall write count", wrQ.size(), 4);
    chkInt("io stall idle cycles", rdQ.size(), 3);
    for (int j = 0; j < wrQ.size(); j++)
      chk($sformatf("io stall byte %0d", j), 128'(wrQ[j]),
          128'({32'h0003_0000 + 32'(j), wdat[j*8 +: 8]}));
    checkGap("io stall gap");

    // IO table
    for (int i = 0; i < 10; i++) begin
      memXor = vecs[i].xorKey;
      ioWriteIn = vecs[i].wr; ioSizeIn = vecs[i].size;
      ioAddrIn = vecs[i].addr; ioDataIn = vecs[i].data; ioReqIn = 1'b1;
      runBurst((vecs[i].expLat == 0) ? 8 : 12, 1, vecs[i].bufFull ? 100 : 0);
      ioReqIn = 1'b0;
      chkInt($sformatf("io%0d latency", i), lat, vecs[i].expLat);
      if (vecs[i].expLat == 0) begin
        chkInt($sformatf("io%0d no activity", i), rdQ.size() + wrQ.size(), 0);
      end else begin
        chk($sformatf("io%0d done", i), 128'(doneMask), 128'(3'b100));
        chk($sformatf("io%0d ioData", i), 128'(ioDataOut), 128'(vecs[i].expData));
        if (vecs[i].wr) begin
          chkInt($sformatf("io%0d write count", i), wrQ.size(), ioLen(vecs[i].size));
          for (int j = 0; j < wrQ.size() && j < 4; j++)
            chk($sformatf("io%0d byte %0d", i, j), 128'(wrQ[j]),
                128'({vecs[i].addr + 32'(j), vecs[i].data[j*8 +: 8]}));
        end else begin
          chkInt($sformatf("io%0d read count", i), rdQ.size(), ioLen(vecs[i].size));
        end
        checkGap($sformatf("io%0d gap", i));
      end
    end

    // all three requesters at once: IO, then DC, then IC
    memXor = 8'h45;
    ioWriteIn = 1'b0; ioSizeIn = SIZE_BYTE; ioAddrIn = 32'h0003_0004; ioReqIn = 1'b1;
    dcWriteIn = 1'b0; dcAddrIn = 28'h3; dcReqIn = 1'b1;
    icAddrIn = 28'h9; icReqIn = 1'b1;
    runBurst(30, 0, 0);
    ioReqIn = 1'b0;
    chk("prio first", 128'(doneMask), 128'(3'b100));
    chkInt("prio io latency", lat, 3);
    chk("prio io data", 128'(ioDataOut), 128'(32'h41));
    checkGap("prio gap1");
    runBurst(30, 0, 0);
    dcReqIn = 1'b0;
    chk("prio second", 128'(doneMask), 128'(3'b010));
    chkInt("prio dc latency", lat, 18);
    chk("prio dc line", dcLineOut, lineOf(32'h30, 8'h45));
    checkGap("prio gap2");
    runBurst(30, 0, 0);
    icReqIn = 1'b0;
    chk("prio third", 128'(doneMask), 128'(3'b001));
    chkInt("prio ic latency", lat, 18);
    expIcLine = lineOf(32'h90, 8'h45);
    chk("prio ic line", icLineOut, expIcLine);
    checkGap("prio gap3");
    runBurst(6, 0, 0);
    chkInt("prio no extra done", lat, 0);

    // clearIn aborts an ICache refill at cnt=5; pending DCache refill follows
    memXor = 8'h00; icAddrIn = 28'h4; icReqIn = 1'b1;
    icDones = 0; dcLat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clkIn);
      if (k == 2) begin dcAddrIn = 28'h5; dcWriteIn = 1'b0; dcReqIn = 1'b1; end
      if (k == 6) clearIn = 1'b1;
      if (k == 7) begin clearIn = 1'b0; icReqIn = 1'b0; end
      #1;
      if (k == 6) chk("abort addr at cnt5", 128'(memAddrOut), 128'(32'h45));
      if (k == 7) chk("abort idle cycle", 128'({memWriteOut, memAddrOut}), 128'(0));
      if (icDoneOut) icDones++;
      if (dcDoneOut) begin dcLat = k; break; end
    end
    dcReqIn = 1'b0;
    chkInt("abort no ic done", icDones, 0);
    chkInt("abort dc latency", dcLat, 25);
    chk("abort icLine kept", icLineOut, expIcLine);
    chk("abort dc line", dcLineOut, lineOf(32'h50, 8'h00));
    checkGap("abort gap");

    // clearIn in idle holds off an ICache grant
    clearIn = 1'b1; icAddrIn = 28'h4; icReqIn = 1'b1; act = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clkIn);
      #1;
      if (memAddrOut != 0 || memWriteOut) act++;
    end
    chkInt("clear blocks ic grant", act, 0);
    clearIn = 1'b0;
    runBurst(30, 0, 0);
    icReqIn = 1'b0;
    chkInt("post-clear ic latency", lat, 18);
    expIcLine = lineOf(32'h40, 8'h00);
    chk("post-clear ic line", icLineOut, expIcLine);
    checkGap("post-clear gap");

    // reset in the middle of a DCache write-back
    for (int k = 0; k < 16; k++) dcLineIn[k*8 +: 8] = 8'hA5 ^ 8'(k);
    dcAddrIn = 28'h6; dcWriteIn = 1'b1; dcReqIn = 1'b1;
    repeat (5) @(negedge clkIn);
    #1;
    chk("pre-reset write active", 128'({memWriteOut, memAddrOut, memOut}),
        128'({1'b1, 32'h64, 8'hA1}));
    resetIn = 1'b0;
    #1;
    chk("mid reset mem port", 128'({memAddrOut, memOut, memWriteOut}), 128'(0));
    chk("mid reset dones", 128'({icDoneOut, dcDoneOut, ioDoneOut}), 128'(0));
    chk("mid reset icLine", icLineOut, 128'(0));
    chk("mid reset dcLine", dcLineOut, 128'(0));
    chk("mid reset ioData", 128'(ioDataOut), 128'(0));
    dcReqIn = 1'b0; dcWriteIn = 1'b0;
    @(negedge clkIn);
    resetIn = 1'b1;
    memXor = 8'h45; ioWriteIn = 1'b0; ioSizeIn = SIZE_BYTE; ioAddrIn = 32'h0003_0004; ioReqIn = 1'b1;
    runBurst(12, 0, 0);
    ioReqIn = 1'b0;
    chkInt("post-reset io latency", lat, 3);
    chk("post-reset io data", 128'(ioDataOut), 128'(32'h41));
    checkGap("post-reset gap");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
